// File: rtl/wt_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : wt_mem_responder
// Brief    : Write-through cache memory responder; serves icache/dcache
//            requests from a word array with a fixed return latency.
// Revision : 1.0
// ============================================================================
module wt_mem_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int LINE_WORDS = 2,
    parameter int LATENCY    = 4,
    parameter int TID_WIDTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       icache_data_req_i,
    output logic                       icache_data_ack_o,
    input  logic [63:0]                icache_paddr_i,
    input  logic [TID_WIDTH-1:0]       icache_tid_i,
    output logic                       icache_rtrn_vld_o,
    output logic [64*LINE_WORDS-1:0]   icache_rtrn_data_o,
    output logic [TID_WIDTH-1:0]       icache_rtrn_tid_o,
    input  logic                       dcache_data_req_i,
    output logic                       dcache_data_ack_o,
    input  logic [1:0]                 dcache_rtype_i,
    input  logic [63:0]                dcache_paddr_i,
    input  logic [1:0]                 dcache_size_i,
    input  logic [63:0]                dcache_wdata_i,
    input  logic [TID_WIDTH-1:0]       dcache_tid_i,
    output logic                       dcache_rtrn_vld_o,
    output logic [1:0]                 dcache_rtrn_type_o,
    output logic [64*LINE_WORDS-1:0]   dcache_rtrn_data_o,
    output logic [TID_WIDTH-1:0]       dcache_rtrn_tid_o,
    output logic                       busy_o
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int LINE_W = 64 * LINE_WORDS;

    localparam logic [IDX_W-1:0] c_LINE_MASK    = ~(IDX_W'(LINE_WORDS - 1));
    localparam logic [1:0]       c_RT_LOAD      = 2'd0;
    localparam logic [1:0]       c_RT_STORE     = 2'd1;
    localparam logic [1:0]       c_RR_LOAD_ACK  = 2'd0;
    localparam logic [1:0]       c_RR_STORE_ACK = 2'd1;
    localparam logic [1:0]       c_RR_ERR       = 2'd3;

    typedef struct packed {
        logic                 vld;
        logic                 port;   // 1 = dcache
        logic [1:0]           rtype;
        logic [TID_WIDTH-1:0] tid;
        logic [LINE_W-1:0]    data;
    } ret_t;

    logic [63:0]          r_mem [MEM_WORDS];
    logic                 r_rr_dcache;
    logic                 w_grant_i;
    logic                 w_grant_d;
    logic [63:0]          w_paddr;
    logic [IDX_W-1:0]     w_idx;
    logic [IDX_W-1:0]     w_base;
    logic [LINE_W-1:0]    w_rd_line;
    logic [7:0]           w_be_base;
    logic [15:0]          w_be_wide;
    logic [7:0]           w_be;
    logic                 w_store;
    ret_t                 w_new;
    ret_t                 w_tail;
    logic                 w_pipe_busy;
    logic                 r_i_vld;
    logic [LINE_W-1:0]    r_i_data;
    logic [TID_WIDTH-1:0] r_i_tid;
    logic                 r_d_vld;
    logic [1:0]           r_d_type;
    logic [LINE_W-1:0]    r_d_data;
    logic [TID_WIDTH-1:0] r_d_tid;
    logic                 w_unused;

    // Grant is combinational; reset masks it so nothing is accepted while held.
    assign w_grant_i = ~rst_i & icache_data_req_i & (~dcache_data_req_i | ~r_rr_dcache);
    assign w_grant_d = ~rst_i & dcache_data_req_i & (~icache_data_req_i | r_rr_dcache);

    assign icache_data_ack_o = w_grant_i;
    assign dcache_data_ack_o = w_grant_d;

    assign w_paddr = w_grant_d ? dcache_paddr_i : icache_paddr_i;
    assign w_idx   = w_paddr[3 +: IDX_W];
    assign w_base  = w_idx & c_LINE_MASK;

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_rd_line
        assign w_rd_line[64*k +: 64] = r_mem[w_base | IDX_W'(k)];
    end

    always_comb begin
        w_be_base = 8'h00;
        case (dcache_size_i)
            2'd0:    w_be_base = 8'h01;
            2'd1:    w_be_base = 8'h03;
            2'd2:    w_be_base = 8'h0F;
            default: w_be_base = 8'hFF;
        endcase
    end

    // Bytes shifted past lane 7 by a misaligned access are discarded.
    assign w_be_wide = {8'h00, w_be_base} << dcache_paddr_i[2:0];
    assign w_be      = w_be_wide[7:0];
    assign w_store   = w_grant_d & (dcache_rtype_i == c_RT_STORE);

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= dcache_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_new      = '0;
        w_new.vld  = w_grant_i | w_grant_d;
        w_new.port = w_grant_d;
        if (w_grant_d) begin
            w_new.tid = dcache_tid_i;
            if (dcache_rtype_i == c_RT_LOAD) begin
                w_new.rtype = c_RR_LOAD_ACK;
                w_new.data  = w_rd_line;
            end else if (dcache_rtype_i == c_RT_STORE) begin
                w_new.rtype = c_RR_STORE_ACK;
            end else begin
                w_new.rtype = c_RR_ERR;
            end
        end else begin
            w_new.tid  = icache_tid_i;
            w_new.data = w_rd_line;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_dcache <= 1'b0;
        end else if (w_grant_i) begin
            r_rr_dcache <= 1'b1;
        end else if (w_grant_d) begin
            r_rr_dcache <= 1'b0;
        end
    end

    // The per-port output registers form the final delay stage, so only
    // LATENCY-1 shared stages sit in front of them.
    if (LATENCY > 1) begin : g_pipe
        ret_t r_pipe [LATENCY-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s < LATENCY - 1; s++) begin
                    r_pipe[s] <= '0;
                end
            end else begin
                r_pipe[0] <= w_new;
                for (int s = 1; s < LATENCY - 1; s++) begin
                    r_pipe[s] <= r_pipe[s-1];
                end
            end
        end

        always_comb begin
            w_pipe_busy = 1'b0;
            for (int s = 0; s < LATENCY - 1; s++) begin
                w_pipe_busy = w_pipe_busy | r_pipe[s].vld;
            end
        end

        assign w_tail = r_pipe[LATENCY-2];
    end else begin : g_nopipe
        assign w_pipe_busy = 1'b0;
        assign w_tail      = w_new;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_i_vld  <= 1'b0;
            r_i_data <= '0;
            r_i_tid  <= '0;
            r_d_vld  <= 1'b0;
            r_d_type <= 2'd0;
            r_d_data <= '0;
            r_d_tid  <= '0;
        end else begin
            r_i_vld <= w_tail.vld & ~w_tail.port;
            r_d_vld <= w_tail.vld & w_tail.port;
            if (w_tail.vld & ~w_tail.port) begin
                r_i_data <= w_tail.data;
                r_i_tid  <= w_tail.tid;
            end
            if (w_tail.vld & w_tail.port) begin
                r_d_type <= w_tail.rtype;
                r_d_data <= w_tail.data;
                r_d_tid  <= w_tail.tid;
            end
        end
    end

    assign icache_rtrn_vld_o  = r_i_vld;
    assign icache_rtrn_data_o = r_i_data;
    assign icache_rtrn_tid_o  = r_i_tid;
    assign dcache_rtrn_vld_o  = r_d_vld;
    assign dcache_rtrn_type_o = r_d_type;
    assign dcache_rtrn_data_o = r_d_data;
    assign dcache_rtrn_tid_o  = r_d_tid;

    assign busy_o = ~rst_i & (icache_data_req_i | dcache_data_req_i |
                              w_pipe_busy | r_i_vld | r_d_vld);

    assign w_unused = ^{w_paddr[63:3+IDX_W], w_paddr[2:0], w_be_wide[15:8]};

endmodule
`default_nettype wire

// File: tb/tb_wt_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_mem_responder
// Brief    : Self-checking bench: transaction-level memory/return model plus
//            directed vectors with literal expectations.
// Revision : 1.0
// ============================================================================
module tb_wt_mem_responder;

    localparam int MW  = 1024;
    localparam int LW  = 2;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         icache_data_req_i, icache_data_ack_o;
    logic [63:0]  icache_paddr_i;
    logic [1:0]   icache_tid_i;
    logic         icache_rtrn_vld_o;
    logic [127:0] icache_rtrn_data_o;
    logic [1:0]   icache_rtrn_tid_o;
    logic         dcache_data_req_i, dcache_data_ack_o;
    logic [1:0]   dcache_rtype_i;
    logic [63:0]  dcache_paddr_i;
    logic [1:0]   dcache_size_i;
    logic [63:0]  dcache_wdata_i;
    logic [1:0]   dcache_tid_i;
    logic         dcache_rtrn_vld_o;
    logic [1:0]   dcache_rtrn_type_o;
    logic [127:0] dcache_rtrn_data_o;
    logic [1:0]   dcache_rtrn_tid_o;
    logic         busy_o;

    wt_mem_responder #(
        .MEM_WORDS(MW), .LINE_WORDS(LW), .LATENCY(LAT), .TID_WIDTH(2)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .icache_data_req_i(icache_data_req_i), .icache_data_ack_o(icache_data_ack_o),
        .icache_paddr_i(icache_paddr_i), .icache_tid_i(icache_tid_i),
        .icache_rtrn_vld_o(icache_rtrn_vld_o), .icache_rtrn_data_o(icache_rtrn_data_o),
        .icache_rtrn_tid_o(icache_rtrn_tid_o),
        .dcache_data_req_i(dcache_data_req_i), .dcache_data_ack_o(dcache_data_ack_o),
        .dcache_rtype_i(dcache_rtype_i), .dcache_paddr_i(dcache_paddr_i),
        .dcache_size_i(dcache_size_i), .dcache_wdata_i(dcache_wdata_i),
        .dcache_tid_i(dcache_tid_i),
        .dcache_rtrn_vld_o(dcache_rtrn_vld_o), .dcache_rtrn_type_o(dcache_rtrn_type_o),
        .dcache_rtrn_data_o(dcache_rtrn_data_o), .dcache_rtrn_tid_o(dcache_rtrn_tid_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        bit           port;
        logic [1:0]   typ;
        logic [1:0]   tid;
        logic [127:0] data;
        bit           known;
    } ret_t;

    ret_t         q[$];
    logic [63:0]  mm [MW];
    bit           mk [MW];
    bit           ptr_d = 1'b0;
    logic [127:0] li_data = '0, ld_data = '0;
    logic [1:0]   li_tid = '0, ld_tid = '0, ld_typ = '0;
    bit           li_kn = 1'b1, ld_kn = 1'b1;
    int           ipulses = 0;

    function automatic int widx(input logic [63:0] pa);
        return int'((pa >> 3) % MW);
    endfunction

    task automatic rd_line(input int idx, output logic [127:0] d, output bit kn);
        int base;
        base = idx - (idx % LW);
        kn   = 1'b1;
        d    = '0;
        for (int k = 0; k < LW; k++) begin
            d[64*k +: 64] = mm[base + k];
            if (!mk[base + k]) kn = 1'b0;
        end
    endtask

    always @(negedge clk) if (icache_rtrn_vld_o) ipulses++;

    always @(negedge clk) begin
        ret_t e;
        bit   ei, ed, evi, evd;
        int   be;
        int   idx;
        if (rst_i) begin
            q.delete();
            ptr_d   = 1'b0;
            li_data = '0; li_tid = '0; li_kn = 1'b1;
            ld_data = '0; ld_tid = '0; ld_typ = '0; ld_kn = 1'b1;
            chk("rst_acks", {icache_data_ack_o, dcache_data_ack_o}, 2'b00);
            chk("rst_vlds", {icache_rtrn_vld_o, dcache_rtrn_vld_o}, 2'b00);
            chk("rst_busy", busy_o, 1'b0);
        end else begin
            chk("busy", busy_o, icache_data_req_i | dcache_data_req_i | (q.size() != 0));
            ei = icache_data_req_i && (!dcache_data_req_i || !ptr_d);
            ed = dcache_data_req_i && (!icache_data_req_i || ptr_d);
            chk("i_ack", icache_data_ack_o, ei);
            chk("d_ack", dcache_data_ack_o, ed);

            evi = 1'b0;
            evd = 1'b0;
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.port) begin
                    evd = 1'b1; ld_data = e.data; ld_tid = e.tid; ld_typ = e.typ; ld_kn = e.known;
                end else begin
                    evi = 1'b1; li_data = e.data; li_tid = e.tid; li_kn = e.known;
                end
            end
            chk("i_vld", icache_rtrn_vld_o, evi);
            chk("d_vld", dcache_rtrn_vld_o, evd);
            chk("i_tid", icache_rtrn_tid_o, li_tid);
            chk("d_tid", dcache_rtrn_tid_o, ld_tid);
            chk("d_type", dcache_rtrn_type_o, ld_typ);
            if (li_kn) chk("i_data", icache_rtrn_data_o, li_data);
            if (ld_kn) chk("d_data", dcache_rtrn_data_o, ld_data);

            if (ei) begin
                e      = '{default: '0};
                e.due  = cyc + LAT;
                e.port = 1'b0;
                e.tid  = icache_tid_i;
                rd_line(widx(icache_paddr_i), e.data, e.known);
                q.push_back(e);
                ptr_d = 1'b1;
            end else if (ed) begin
                e       = '{default: '0};
                e.due   = cyc + LAT;
                e.port  = 1'b1;
                e.tid   = dcache_tid_i;
                e.known = 1'b1;
                idx     = widx(dcache_paddr_i);
                if (dcache_rtype_i == 2'd0) begin
                    e.typ = 2'd0;
                    rd_line(idx, e.data, e.known);
                end else if (dcache_rtype_i == 2'd1) begin
                    e.typ = 2'd1;
                    be = (((1 << (1 << dcache_size_i)) - 1) << dcache_paddr_i[2:0]) & 255;
                    for (int b = 0; b < 8; b++)
                        if (be[b]) mm[idx][8*b +: 8] = dcache_wdata_i[8*b +: 8];
                    if (be == 255) mk[idx] = 1'b1;
                end else begin
                    e.typ = 2'd3;
                end
                q.push_back(e);
                ptr_d = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (entered just after a posedge) -------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic ireq(input logic [63:0] pa, input logic [1:0] tid, output int ac);
        icache_paddr_i    = pa;
        icache_tid_i      = tid;
        icache_data_req_i = 1'b1;
        ac = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (icache_data_ack_o) begin
                ac = cyc;
                break;
            end
        end
        if (ac < 0) chk("i_ack_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        icache_data_req_i = 1'b0;
    endtask

    task automatic dreq(input logic [1:0] rt, input logic [63:0] pa, input logic [1:0] sz,
                        input logic [63:0] wd, input logic [1:0] tid, output int ac);
        dcache_rtype_i    = rt;
        dcache_paddr_i    = pa;
        dcache_size_i     = sz;
        dcache_wdata_i    = wd;
        dcache_tid_i      = tid;
        dcache_data_req_i = 1'b1;
        ac = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (dcache_data_ack_o) begin
                ac = cyc;
                break;
            end
        end
        if (ac < 0) chk("d_ack_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        dcache_data_req_i = 1'b0;
    endtask

    task automatic wait_neg(input int target);
        int n;
        n = 0;
        @(negedge clk);
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cycle", cyc, target);
    endtask

    int t1, t2, a, b, ia1, da1, ia2, da2, pre;
    int acs [8];

    initial begin
        rst_i = 1'b1;
        icache_data_req_i = 1'b0; icache_paddr_i = '0; icache_tid_i = '0;
        dcache_data_req_i = 1'b0; dcache_rtype_i = '0; dcache_paddr_i = '0;
        dcache_size_i = '0; dcache_wdata_i = '0; dcache_tid_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("reset_vld", {icache_rtrn_vld_o, dcache_rtrn_vld_o}, 2'b00);
        chk("reset_data", icache_rtrn_data_o, 128'h0);
        chk("reset_busy", busy_o, 1'b0);

        for (int i = 0; i < 16; i++)
            dreq(2'd1, 64'(8 * i), 2'd3, 64'h0123_4567_0000_0000 | 64'(i), 2'(i), a);
        dreq(2'd1, 64'h1000, 2'd3, 64'h1234_5678_9ABC_DEF0, 2'd0, a);

        // store then immediately load the same line
        dreq(2'd1, 64'h1008, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 2'd1, t1);
        dreq(2'd0, 64'h1000, 2'd0, 64'h0, 2'd2, t2);
        chk("store_load_b2b", t2, t1 + 1);
        wait_neg(t1 + 4);
        chk("st_ack_vld", dcache_rtrn_vld_o, 1'b1);
        chk("st_ack_type", dcache_rtrn_type_o, 2'd1);
        chk("st_ack_tid", dcache_rtrn_tid_o, 2'd1);
        chk("st_ack_data", dcache_rtrn_data_o, 128'h0);
        wait_neg(t1 + 5);
        chk("ld_vld", dcache_rtrn_vld_o, 1'b1);
        chk("ld_type", dcache_rtrn_type_o, 2'd0);
        chk("ld_tid", dcache_rtrn_tid_o, 2'd2);
        chk("ld_data", dcache_rtrn_data_o,
            128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0);

        // byte store, then misaligned halfword whose upper byte overflows
        sync();
        dreq(2'd1, 64'h2000, 2'd3, 64'h0, 2'd0, a);
        dreq(2'd1, 64'h2003, 2'd0, 64'h0000_0000_AA00_0000, 2'd1, a);
        dreq(2'd0, 64'h2000, 2'd0, 64'h0, 2'd3, a);
        wait_neg(a + 4);
        chk("byte_store", dcache_rtrn_data_o[63:0], 64'h0000_0000_AA00_0000);
        sync();
        dreq(2'd1, 64'h2007, 2'd1, 64'hBB00_0000_0000_0000, 2'd0, a);
        dreq(2'd0, 64'h2000, 2'd0, 64'h0, 2'd2, a);
        wait_neg(a + 4);
        chk("misaligned_store", dcache_rtrn_data_o,
            128'h0123_4567_0000_0001_BB00_0000_AA00_0000);

        // arbitration after reset
        sync();
        rst_i = 1'b1;
        sync();
        rst_i = 1'b0;
        fork
            ireq(64'h20, 2'd1, ia1);
            dreq(2'd0, 64'h1000, 2'd0, 64'h0, 2'd2, da1);
        join
        fork
            ireq(64'h30, 2'd2, ia2);
            dreq(2'd0, 64'h10, 2'd0, 64'h0, 2'd3, da2);
        join
        chk("arb_d1", da1, ia1 + 1);
        chk("arb_i2", ia2, ia1 + 2);
        chk("arb_d2", da2, ia1 + 3);
        wait_neg(ia1 + 4);
        chk("arb_i_rtrn", icache_rtrn_vld_o, 1'b1);
        chk("arb_i_data", icache_rtrn_data_o,
            128'h0123_4567_0000_0005_0123_4567_0000_0004);
        wait_neg(ia1 + 5);
        chk("arb_d_rtrn", dcache_rtrn_vld_o, 1'b1);
        wait_neg(ia1 + 8);

        // eight back-to-back icache fills
        sync();
        pre = ipulses;
        for (int i = 0; i < 8; i++) ireq(64'(16 * i), 2'(i % 4), acs[i]);
        for (int i = 1; i < 8; i++) chk("b2b_ack", acs[i], acs[0] + i);
        wait_neg(acs[7] + 5);
        chk("b2b_pulses", ipulses - pre, 8);

        // reset with two returns in flight
        sync();
        ireq(64'h40, 2'd0, a);
        ireq(64'h50, 2'd1, b);
        icache_paddr_i    = 64'h60;
        icache_data_req_i = 1'b1;
        rst_i             = 1'b1;
        @(negedge clk);
        chk("midrst_ack", icache_data_ack_o, 1'b0);
        chk("midrst_vld", icache_rtrn_vld_o, 1'b0);
        sync();
        rst_i             = 1'b0;
        icache_data_req_i = 1'b0;
        pre = ipulses;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_rtrn", ipulses, pre);
        chk("midrst_busy", busy_o, 1'b0);

        // reserved rtype, then contents unchanged and aliasing
        dreq(2'd2, 64'h1008, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, a);
        wait_neg(a + 4);
        chk("err_type", dcache_rtrn_type_o, 2'd3);
        chk("err_data", dcache_rtrn_data_o, 128'h0);
        sync();
        dreq(2'd0, 64'h1008, 2'd0, 64'h0, 2'd1, a);
        wait_neg(a + 4);
        chk("err_no_effect", dcache_rtrn_data_o[127:64], 64'hDEAD_BEEF_CAFE_F00D);
        sync();
        dreq(2'd0, 64'h1008 + 64'(MW * 8), 2'd0, 64'h0, 2'd2, a);
        wait_neg(a + 4);
        chk("alias_data", dcache_rtrn_data_o,
            128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
